// File: rtl/imm_pkg.sv
// Shared types for the immediate decoder: format enum, opcode map and decoded record.
package imm_pkg;

    localparam int XLEN_MAX = 64;

    typedef enum logic [2:0] {
        FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_Z, FMT_NONE
    } fmt_e;

    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_FENCE     = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;

    // Sized for the widest datapath; narrower builds use the low XLEN bits.
    typedef struct packed {
        logic [XLEN_MAX-1:0] imm;
        fmt_e                fmt;
        logic                illegal;
        logic [XLEN_MAX-1:0] pc;
        logic [XLEN_MAX-1:0] target;
    } dec_t;

endpackage

// File: rtl/imm_decode_pipe_if.sv
// Fetch-side and execute-side handshakes of the immediate decoder.
interface imm_decode_pipe_if #(parameter int XLEN = 32);

    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_fmt;
    logic            out_illegal;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_target;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_pc, out_target
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_pc, out_target
    );

endinterface

// File: rtl/imm_extract.sv
// Combinational format classification, immediate extraction and target computation.
// Define IMM_CSR_EN to decode CSR-immediate SYSTEM instructions as Z-format.
module imm_extract
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    output dec_t            dec
);

    logic signed [31:0] imm32;
    fmt_e               fmt;
    logic               illegal;
    logic               pc_rel;
    logic [XLEN-1:0]    imm_x;
    logic [XLEN-1:0]    target;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        imm32   = '0;
        fmt     = FMT_NONE;
        illegal = 1'b0;
        pc_rel  = 1'b0;
        unique case (instr[6:0])
            OPC_OP: fmt = FMT_R;
            OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_FENCE: begin
                fmt   = FMT_I;
                imm32 = {{20{instr[31]}}, instr[31:20]};
            end
            OPC_SYSTEM: begin
`ifdef IMM_CSR_EN
                if (instr[14] && instr[13:12] != 2'b00) begin
                    fmt   = FMT_Z;
                    imm32 = {27'b0, instr[19:15]};
                end else begin
                    fmt   = FMT_I;
                    imm32 = {{20{instr[31]}}, instr[31:20]};
                end
`else
                fmt   = FMT_I;
                imm32 = {{20{instr[31]}}, instr[31:20]};
`endif
            end
            OPC_STORE: begin
                fmt   = FMT_S;
                imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            OPC_BRANCH: begin
                fmt    = FMT_B;
                pc_rel = 1'b1;
                imm32  = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            OPC_LUI: begin
                fmt   = FMT_U;
                imm32 = {instr[31:12], 12'b0};
            end
            OPC_AUIPC: begin
                fmt    = FMT_U;
                pc_rel = 1'b1;
                imm32  = {instr[31:12], 12'b0};
            end
            OPC_JAL: begin
                fmt    = FMT_J;
                pc_rel = 1'b1;
                imm32  = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            OPC_OP_32: begin
                if (XLEN == 64) fmt = FMT_R;
                else            illegal = 1'b1;
            end
            OPC_OP_IMM_32: begin
                if (XLEN == 64) begin
                    fmt   = FMT_I;
                    imm32 = {{20{instr[31]}}, instr[31:20]};
                end else begin
                    illegal = 1'b1;
                end
            end
            default: illegal = 1'b1;
        endcase
    end

    // imm32 is signed, so the size cast sign-extends into the wider datapath.
    assign imm_x  = XLEN'(imm32);
    assign target = pc + (pc_rel ? imm_x : XLEN'(4));

    always_comb begin
        dec         = '0;
        dec.imm     = XLEN_MAX'(imm_x);
        dec.fmt     = fmt;
        dec.illegal = illegal;
        dec.pc      = XLEN_MAX'(pc);
        dec.target  = XLEN_MAX'(target);
    end

endmodule

// File: rtl/imm_decode_pipe.sv
// Registered immediate decoder with a 2-entry skid buffer, flush and saturating illegal counter.
// Optional IMM_CSR_EN (see imm_extract) enables Z-format CSR-immediate decoding.
module imm_decode_pipe
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    imm_decode_pipe_if.slave    bus,
    output logic [CNT_W-1:0]    illegal_cnt
);

    generate
        if (XLEN != 32 && XLEN != 64) begin : g_xlen_check
            $error("imm_decode_pipe: XLEN must be 32 or 64");
        end
    endgenerate

    dec_t             dec;
    dec_t             main_q;
    dec_t             skid_q;
    logic             main_valid_q;
    logic             skid_valid_q;
    logic             accept;
    logic             main_free;
    logic [CNT_W-1:0] cnt_q;

    imm_extract #(.XLEN(XLEN)) u_extract (
        .instr (bus.in_instr),
        .pc    (bus.in_pc),
        .dec   (dec)
    );

    // Skid occupancy alone gates acceptance, so in_ready comes straight from a flop.
    assign accept    = bus.in_valid && !skid_valid_q && !flush;
    assign main_free = !main_valid_q || bus.out_ready;

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    // NOTE: the data entries are reset too because their contents drive the outputs directly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (flush) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (main_free) begin
            if (skid_valid_q) begin
                main_q       <= skid_q;
                main_valid_q <= 1'b1;
                skid_valid_q <= 1'b0;
            end else if (accept) begin
                main_q       <= dec;
                main_valid_q <= 1'b1;
            end else begin
                main_valid_q <= 1'b0;
            end
        end else if (accept) begin
            skid_q       <= dec;
            skid_valid_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (accept && dec.illegal && cnt_q != {CNT_W{1'b1}}) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.in_ready    = !skid_valid_q;
    assign bus.out_valid   = main_valid_q;
    assign bus.out_imm     = main_q.imm[XLEN-1:0];
    assign bus.out_fmt     = main_q.fmt;
    assign bus.out_illegal = main_q.illegal;
    assign bus.out_pc      = main_q.pc[XLEN-1:0];
    assign bus.out_target  = main_q.target[XLEN-1:0];
    assign illegal_cnt     = cnt_q;

    generate
        if (XLEN < XLEN_MAX) begin : g_narrow
            logic unused_hi;
            assign unused_hi = ^{main_q.imm[XLEN_MAX-1:XLEN], main_q.pc[XLEN_MAX-1:XLEN],
                                 main_q.target[XLEN_MAX-1:XLEN]};
        end
    endgenerate

endmodule
